// File: rtl/pmic_pkg.sv
// Shared encodings and default timing for the PMIC rail responder.
package pmic_pkg;

   typedef enum logic [1:0] {
      RAIL_OFF     = 2'b00,
      RAIL_RAMP_UP = 2'b01,
      RAIL_GOOD    = 2'b10,
      RAIL_RAMP_DN = 2'b11
   } rail_state_e;

   typedef enum logic [1:0] {
      FLT_NONE     = 2'b00,
      FLT_2V_EARLY = 2'b01,
      FLT_3V_EARLY = 2'b10,
      FLT_DN_ORDER = 2'b11
   } fault_code_e;

   localparam int unsigned DEF_CNT_W        = 28;
   localparam int unsigned DEF_RAMP_CYCLES  = 50_000_000;
   localparam int unsigned DEF_DISCH_CYCLES = 25_000_000;

endpackage

// File: rtl/pmic_rail_model.sv
// One rail: OFF/RAMP_UP/GOOD/RAMP_DN FSM with a saturating down-counter and
// a registered power-good flag.
module pmic_rail_model
   import pmic_pkg::*;
#(
   parameter int unsigned CNT_W        = DEF_CNT_W,
   parameter int unsigned RAMP_CYCLES  = DEF_RAMP_CYCLES,
   parameter int unsigned DISCH_CYCLES = DEF_DISCH_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en_i,
   output logic [1:0] state_o,
   output logic       pg_o,
   output logic       pg_next_o
);

   localparam logic [CNT_W-1:0] RampLoad  = CNT_W'(RAMP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DischLoad = CNT_W'(DISCH_CYCLES - 1);

   rail_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pg_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RAIL_OFF: begin
            if (en_i) begin
               state_d = RAIL_RAMP_UP;
               cnt_d   = RampLoad;
            end
         end
         RAIL_RAMP_UP: begin
            if (!en_i) begin
               state_d = RAIL_RAMP_DN;
               cnt_d   = DischLoad;
            end else if (cnt_q == '0) begin
               state_d = RAIL_GOOD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RAIL_GOOD: begin
            if (!en_i) begin
               state_d = RAIL_RAMP_DN;
               cnt_d   = DischLoad;
            end
         end
         RAIL_RAMP_DN: begin
            if (en_i) begin
               state_d = RAIL_RAMP_UP;
               cnt_d   = RampLoad;
            end else if (cnt_q == '0) begin
               state_d = RAIL_OFF;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = RAIL_OFF;
            cnt_d   = '0;
         end
      endcase
   end

   assign pg_next_o = (state_d == RAIL_GOOD);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RAIL_OFF;
         cnt_q   <= '0;
         pg_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pg_q    <= pg_next_o;
      end
   end

   assign state_o = state_q;
   assign pg_o    = pg_q;

endmodule

// File: rtl/pmic_rail_responder.sv
// Load-side model of the 1V/2V/3V rails: per-rail ramp timing, power-good
// flags and a sticky checker for enable up/down ordering.
module pmic_rail_responder
   import pmic_pkg::*;
#(
   parameter int unsigned CNT_W        = DEF_CNT_W,
   parameter int unsigned RAMP_CYCLES  = DEF_RAMP_CYCLES,
   parameter int unsigned DISCH_CYCLES = DEF_DISCH_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en_1v,
   input  logic       en_2v,
   input  logic       en_3v,
   output logic       pg_1v,
   output logic       pg_2v,
   output logic       pg_3v,
   output logic       all_good,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [5:0] rail_state
);

   logic [1:0] st_1v, st_2v, st_3v;
   logic       pg_next_1v, pg_next_2v, pg_next_3v;

   pmic_rail_model #(
      .CNT_W       (CNT_W),
      .RAMP_CYCLES (RAMP_CYCLES),
      .DISCH_CYCLES(DISCH_CYCLES)
   ) u_rail_1v (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en_1v),
      .state_o  (st_1v),
      .pg_o     (pg_1v),
      .pg_next_o(pg_next_1v)
   );

   pmic_rail_model #(
      .CNT_W       (CNT_W),
      .RAMP_CYCLES (RAMP_CYCLES),
      .DISCH_CYCLES(DISCH_CYCLES)
   ) u_rail_2v (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en_2v),
      .state_o  (st_2v),
      .pg_o     (pg_2v),
      .pg_next_o(pg_next_2v)
   );

   pmic_rail_model #(
      .CNT_W       (CNT_W),
      .RAMP_CYCLES (RAMP_CYCLES),
      .DISCH_CYCLES(DISCH_CYCLES)
   ) u_rail_3v (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en_3v),
      .state_o  (st_3v),
      .pg_o     (pg_3v),
      .pg_next_o(pg_next_3v)
   );

   logic        en_1v_q, en_2v_q, en_3v_q;
   logic        fall_1v, rise_2v, fall_2v, rise_3v;
   fault_code_e viol;
   logic        fault_q, fault_d;
   fault_code_e code_q, code_d;
   logic        all_good_q, all_good_d;

   assign fall_1v = ~en_1v & en_1v_q;
   assign rise_2v = en_2v & ~en_2v_q;
   assign fall_2v = ~en_2v & en_2v_q;
   assign rise_3v = en_3v & ~en_3v_q;

   // Priority order makes the lowest nonzero code win on simultaneous violations.
   always_comb begin
      viol = FLT_NONE;
      if (rise_2v && !pg_1v) begin
         viol = FLT_2V_EARLY;
      end else if (rise_3v && !pg_2v) begin
         viol = FLT_3V_EARLY;
      end else if ((fall_1v && en_2v) || (fall_2v && en_3v)) begin
         viol = FLT_DN_ORDER;
      end
   end

   always_comb begin
      fault_d    = fault_q | (viol != FLT_NONE);
      code_d     = fault_q ? code_q : viol;
      all_good_d = pg_next_1v & pg_next_2v & pg_next_3v & ~fault_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_1v_q    <= 1'b0;
         en_2v_q    <= 1'b0;
         en_3v_q    <= 1'b0;
         fault_q    <= 1'b0;
         code_q     <= FLT_NONE;
         all_good_q <= 1'b0;
      end else begin
         en_1v_q    <= en_1v;
         en_2v_q    <= en_2v;
         en_3v_q    <= en_3v;
         fault_q    <= fault_d;
         code_q     <= code_d;
         all_good_q <= all_good_d;
      end
   end

   assign all_good   = all_good_q;
   assign fault      = fault_q;
   assign fault_code = code_q;
   assign rail_state = {st_3v, st_2v, st_1v};

endmodule

// File: tb/tb_pmic_rail_responder.sv
// Directed bench for pmic_rail_responder with RAMP_CYCLES=4, DISCH_CYCLES=3.
module tb_pmic_rail_responder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en_1v = 1'b0;
   logic       en_2v = 1'b0;
   logic       en_3v = 1'b0;
   logic       pg_1v, pg_2v, pg_3v;
   logic       all_good, fault;
   logic [1:0] fault_code;
   logic [5:0] rail_state;

   int checks = 0;
   int failures = 0;

   pmic_rail_responder #(
      .CNT_W       (8),
      .RAMP_CYCLES (4),
      .DISCH_CYCLES(3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en_1v     (en_1v),
      .en_2v     (en_2v),
      .en_3v     (en_3v),
      .pg_1v     (pg_1v),
      .pg_2v     (pg_2v),
      .pg_3v     (pg_3v),
      .all_good  (all_good),
      .fault     (fault),
      .fault_code(fault_code),
      .rail_state(rail_state)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      en_1v = 1'b0;
      en_2v = 1'b0;
      en_3v = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   // Helpers pack outputs: pg={pg_3v,pg_2v,pg_1v}, flt={all_good,fault,fault_code}
   function automatic logic [7:0] pgv();
      return {5'b0, pg_3v, pg_2v, pg_1v};
   endfunction

   function automatic logic [7:0] fltv();
      return {4'b0, all_good, fault, fault_code};
   endfunction

   initial begin
      // 1: reset
      tick(2);
      reset = 1'b0;
      chk("rst_state", {2'b0, rail_state}, 8'b00_000000);
      chk("rst_pg", pgv(), 8'b000);
      chk("rst_flt", fltv(), 8'b0000);
      tick();
      chk("idle_state", {2'b0, rail_state}, 8'b00_000000);
      chk("idle_flt", fltv(), 8'b0000);

      // 2: ordered power-up
      en_1v = 1'b1;
      tick();
      chk("up1_state_e0", {2'b0, rail_state}, 8'b00_000001);
      tick(3);
      chk("up1_pg_e3", pgv(), 8'b000);
      tick();
      chk("up1_pg_e4", pgv(), 8'b001);
      chk("up1_state_e4", {2'b0, rail_state}, 8'b00_000010);
      en_2v = 1'b1;
      tick(4);
      chk("up2_pg_e8", pgv(), 8'b001);
      tick();
      chk("up2_pg_e9", pgv(), 8'b011);
      chk("up2_flt_e9", fltv(), 8'b0000);
      en_3v = 1'b1;
      tick(4);
      chk("up3_pg_e13", pgv(), 8'b011);
      chk("up3_flt_e13", fltv(), 8'b0000);
      tick();
      chk("up3_pg_e14", pgv(), 8'b111);
      chk("up3_flt_e14", fltv(), 8'b1000);
      chk("up3_state_e14", {2'b0, rail_state}, 8'b00_101010);

      // 5a: 1V dropped first while 2V still enabled
      en_1v = 1'b0;
      tick();
      chk("dn_pg", pgv(), 8'b110);
      chk("dn_state", {2'b0, rail_state}, 8'b00_101011);
      chk("dn_flt", fltv(), 8'b0111);

      // 3: 1V and 2V raised together
      do_reset();
      chk("early_rst_flt", fltv(), 8'b0000);
      en_1v = 1'b1;
      en_2v = 1'b1;
      tick();
      chk("early_flt", fltv(), 8'b0101);
      chk("early_state", {2'b0, rail_state}, 8'b00_000101);
      tick(3);
      chk("early_pg_e3", pgv(), 8'b000);
      tick();
      chk("early_pg_e4", pgv(), 8'b011);
      chk("early_flt_e4", fltv(), 8'b0101);

      // 5b: later down-order violation keeps the first code
      en_1v = 1'b0;
      tick();
      chk("keep_code_flt", fltv(), 8'b0101);
      chk("keep_code_pg", pgv(), 8'b010);

      // 4: abort mid-ramp, discharge, restart from RAMP_DN
      do_reset();
      en_1v = 1'b1;
      tick(2);
      en_1v = 1'b0;
      tick();
      chk("abort_state", {2'b0, rail_state}, 8'b00_000011);
      chk("abort_pg", pgv(), 8'b000);
      tick(2);
      chk("disch_state_2", {2'b0, rail_state}, 8'b00_000011);
      tick();
      chk("disch_off", {2'b0, rail_state}, 8'b00_000000);
      chk("disch_pg", pgv(), 8'b000);
      en_1v = 1'b1;
      tick(2);
      en_1v = 1'b0;
      tick();
      chk("rd_state", {2'b0, rail_state}, 8'b00_000011);
      en_1v = 1'b1;
      tick();
      chk("restart_state", {2'b0, rail_state}, 8'b00_000001);
      tick(3);
      chk("restart_pg_e3", pgv(), 8'b000);
      tick();
      chk("restart_pg_e4", pgv(), 8'b001);
      chk("restart_flt", fltv(), 8'b0000);

      // 6: reset mid-ramp with a fault latched
      do_reset();
      en_1v = 1'b1;
      en_2v = 1'b1;
      tick();
      chk("mid_flt_set", fltv(), 8'b0101);
      tick();
      reset = 1'b1;
      en_2v = 1'b0;
      tick();
      chk("mid_rst_pg", pgv(), 8'b000);
      chk("mid_rst_state", {2'b0, rail_state}, 8'b00_000000);
      chk("mid_rst_flt", fltv(), 8'b0000);
      reset = 1'b0;
      tick();
      chk("rel_state", {2'b0, rail_state}, 8'b00_000001);
      chk("rel_flt", fltv(), 8'b0000);
      tick(3);
      chk("rel_pg_e3", pgv(), 8'b000);
      tick();
      chk("rel_pg_e4", pgv(), 8'b001);
      chk("rel_flt_e4", fltv(), 8'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
